// File: rtl/key_sched_ctrl_pkg.sv
// Shared constants, state encoding and the rcon helper for the AES-128 key-schedule controller.
package key_sched_ctrl_pkg;

  localparam int unsigned NR = 10;
  localparam int unsigned KW = 128;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;

  typedef enum logic [1:0] {
    StIdle,
    StExpand,
    StReady
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/key_sched_ctrl_if.sv
// Key-load, expansion-datapath and round-key read signals of the key-schedule controller.
// rk_dec exists only when KEY_SCHED_DEC_EN is defined.
interface key_sched_ctrl_if;
  import key_sched_ctrl_pkg::*;

  logic [KW-1:0] key_in;
  logic          key_valid;
  logic          key_ready;
  logic [KW-1:0] xp_key;
  logic [7:0]    xp_rcon;
  logic [KW-1:0] xp_next;
  logic          rk_rd;
  logic [3:0]    rk_idx;
`ifdef KEY_SCHED_DEC_EN
  logic          rk_dec;
`endif
  logic [KW-1:0] rk_out;
  logic          rk_valid;
  logic          busy;
  logic          done;

  // Requester side: key source, expansion datapath and cipher core.
  modport master (
`ifdef KEY_SCHED_DEC_EN
    output rk_dec,
`endif
    output key_in, key_valid, xp_next, rk_rd, rk_idx,
    input  key_ready, xp_key, xp_rcon, rk_out, rk_valid, busy, done
  );

  modport slave (
`ifdef KEY_SCHED_DEC_EN
    input  rk_dec,
`endif
    input  key_in, key_valid, xp_next, rk_rd, rk_idx,
    output key_ready, xp_key, xp_rcon, rk_out, rk_valid, busy, done
  );

endinterface

// File: rtl/key_sched_ctrl_rk_store.sv
// Round-key register file: one write port, one registered read port with a valid flag.
module key_sched_ctrl_rk_store
  import key_sched_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [3:0]    waddr,
  input  logic [KW-1:0] wdata,
  input  logic          rd,
  input  logic          rd_ok,
  input  logic [3:0]    raddr,
  output logic [KW-1:0] rdata,
  output logic          rvalid
);

  logic [KW-1:0] mem_q [NR+1];
  logic [KW-1:0] rdata_q;
  logic          rvalid_q;

  // Storage is deliberately left out of reset; avail in the controller gates visibility.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else if (rd) begin
      rvalid_q <= rd_ok;
      rdata_q  <= rd_ok ? mem_q[raddr] : '0;
    end else begin
      rvalid_q <= 1'b0;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: rtl/key_sched_ctrl.sv
// Sequences AES-128 key expansion through an external one-round datapath and serves round keys.
// Define KEY_SCHED_DEC_EN to add rk_dec (reverse-order reads for decryption).
module key_sched_ctrl
  import key_sched_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  key_sched_ctrl_if.slave bus
);

  localparam logic [3:0] NrIdx = 4'(NR);

  state_e        state_q;
  logic          key_ready_q;
  logic          busy_q;
  logic          done_q;
  logic [KW-1:0] xp_key_q;
  logic [7:0]    rcon_q;
  logic [3:0]    avail_q;
  logic [3:0]    round_q;

  logic          accept;
  logic          we;
  logic [3:0]    waddr;
  logic [KW-1:0] wdata;
  logic [3:0]    map_idx;
  logic          rd_ok;

  assign accept = bus.key_valid & key_ready_q;

  always_comb begin
    we    = 1'b0;
    waddr = round_q;
    wdata = bus.xp_next;
    if (accept) begin
      we    = 1'b1;
      waddr = 4'd0;
      wdata = bus.key_in;
    end else if (state_q == StExpand) begin
      we = 1'b1;
    end
  end

  always_comb begin
`ifdef KEY_SCHED_DEC_EN
    map_idx = bus.rk_dec ? (NrIdx - bus.rk_idx) : bus.rk_idx;
`else
    map_idx = bus.rk_idx;
`endif
    // Range test on the raw index so the reverse mapping can never wrap into a valid slot.
    rd_ok = (bus.rk_idx <= NrIdx) && (map_idx < avail_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      key_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      xp_key_q    <= '0;
      rcon_q      <= RCON_INIT;
      avail_q     <= 4'd0;
      round_q     <= 4'd0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StReady: begin
          if (accept) begin
            xp_key_q    <= bus.key_in;
            rcon_q      <= RCON_INIT;
            round_q     <= 4'd1;
            avail_q     <= 4'd1;
            state_q     <= StExpand;
            key_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        StExpand: begin
          xp_key_q <= bus.xp_next;
          rcon_q   <= xtime(rcon_q);
          round_q  <= round_q + 4'd1;
          avail_q  <= round_q + 4'd1;
          if (round_q == NrIdx) begin
            state_q     <= StReady;
            key_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          key_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.key_ready = key_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.xp_key    = xp_key_q;
  assign bus.xp_rcon   = rcon_q;

  key_sched_ctrl_rk_store u_store (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .rd     (bus.rk_rd),
    .rd_ok  (rd_ok),
    .raddr  (map_idx),
    .rdata  (bus.rk_out),
    .rvalid (bus.rk_valid)
  );

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Directed bench for key_sched_ctrl with an AES-128 one-round expansion datapath on xp_*.
module tb_key_sched_ctrl;
  import key_sched_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  key_sched_ctrl_if bus ();

  key_sched_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  localparam logic [KW-1:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [KW-1:0] FipsRk1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [KW-1:0] FipsRk10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [KW-1:0] KeyB = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  logic [2047:0] sbox_tab = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    int base;
    base = 2047 - 8 * int'(b);
    return sbox_tab[base -: 8];
  endfunction

  function automatic logic [KW-1:0] next_rk(input logic [KW-1:0] prev, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, rot, t;
    {w0, w1, w2, w3} = prev;
    rot = {w3[23:0], w3[31:24]};
    t = {sub_byte(rot[31:24]), sub_byte(rot[23:16]), sub_byte(rot[15:8]), sub_byte(rot[7:0])}
        ^ {rcon, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [KW-1:0] model_rk(input logic [KW-1:0] key, input int n);
    logic [KW-1:0] k;
    k = key;
    for (int i = 0; i < n; i++) k = next_rk(k, rcon_tab[i]);
    return k;
  endfunction

  // External one-round datapath, combinational as the controller expects.
  always_comb bus.xp_next = next_rk(bus.xp_key, bus.xp_rcon);

  task automatic chk(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard of expected read responses.
  typedef struct packed {
    logic          v;
    logic [KW-1:0] d;
  } rd_exp_t;
  rd_exp_t sb[$];
  string   sb_tag[$];
  logic    rd_seen = 1'b0;

  always @(posedge clk) rd_seen <= bus.rk_rd;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", KW'(1), KW'(0));
      end else begin
        rd_exp_t e;
        string   tg;
        e  = sb.pop_front();
        tg = sb_tag.pop_front();
        chk({tg, "_valid"}, KW'(bus.rk_valid), KW'(e.v));
        chk({tg, "_data"}, bus.rk_out, e.d);
      end
    end
  end

  task automatic rd_issue(input logic [3:0] idx, input logic v, input logic [KW-1:0] d,
                          input string tag);
    bus.rk_rd  = 1'b1;
    bus.rk_idx = idx;
    sb.push_back('{v: v, d: d});
    sb_tag.push_back(tag);
  endtask

  task automatic read_one(input logic [3:0] idx, input logic v, input logic [KW-1:0] d,
                          input string tag);
    @(negedge clk);
    rd_issue(idx, v, d, tag);
    @(negedge clk);
    bus.rk_rd = 1'b0;
    @(negedge clk);
  endtask

  // Leaves key_valid asserted at the current negedge; that cycle counts as cycle 0.
  task automatic load_key(input logic [KW-1:0] k);
    int w;
    w = 0;
    @(negedge clk);
    while (bus.key_ready !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("ready_for_key", KW'(bus.key_ready), KW'(1));
    bus.key_valid = 1'b1;
    bus.key_in    = k;
  endtask

  task automatic wait_done(input int start, input string tag);
    int cyc;
    cyc = start;
    while (bus.done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk(tag, KW'(cyc), KW'(11));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cyc;
    int saw;
    bus.key_in    = '0;
    bus.key_valid = 1'b0;
    bus.rk_rd     = 1'b0;
    bus.rk_idx    = '0;
`ifdef KEY_SCHED_DEC_EN
    bus.rk_dec    = 1'b0;
`endif

    // Reset state
    @(negedge clk);
    chk("rst_key_ready", KW'(bus.key_ready), KW'(1));
    chk("rst_busy", KW'(bus.busy), KW'(0));
    chk("rst_done", KW'(bus.done), KW'(0));
    chk("rst_rk_valid", KW'(bus.rk_valid), KW'(0));
    chk("rst_rk_out", bus.rk_out, '0);
    chk("rst_xp_key", bus.xp_key, '0);
    chk("rst_xp_rcon", KW'(bus.xp_rcon), KW'(8'h01));
    @(negedge clk);
    reset = 1'b1;

    // FIPS-197 key: latency, rcon sequence, early read blocked by avail
    load_key(FipsKey);
    done_cyc = 0;
    for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (c == 1) bus.key_valid = 1'b0;
      if (c == 3) bus.rk_rd = 1'b0;
      if (c <= 10) begin
        chk($sformatf("rcon_step%0d", c), KW'(bus.xp_rcon), KW'(rcon_tab[c-1]));
        chk($sformatf("busy_step%0d", c), KW'(bus.busy), KW'(1));
      end
      if (c == 2) rd_issue(4'd3, 1'b0, '0, "rd3_expand");
      if (bus.done === 1'b1) done_cyc = c;
    end
    chk("done_latency", KW'(done_cyc), KW'(11));
    @(negedge clk);
    chk("done_one_pulse", KW'(bus.done), KW'(0));
    chk("ready_after_done", KW'(bus.key_ready), KW'(1));
    chk("idle_after_done", KW'(bus.busy), KW'(0));

    read_one(4'd0, 1'b1, FipsKey, "rd0_fips");
    read_one(4'd1, 1'b1, FipsRk1, "rd1_fips");
    read_one(4'd3, 1'b1, model_rk(FipsKey, 3), "rd3_after_done");
    read_one(4'd11, 1'b0, '0, "rd11_range");
    read_one(4'd10, 1'b1, FipsRk10, "rd10_fips");
    chk("hold_valid", KW'(bus.rk_valid), KW'(0));
    chk("hold_data", bus.rk_out, FipsRk10);

    // Reset at round 5 aborts cleanly
    load_key(FipsKey);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) bus.key_valid = 1'b0;
    end
    reset = 1'b0;
    #1;
    chk("abort_busy", KW'(bus.busy), KW'(0));
    chk("abort_key_ready", KW'(bus.key_ready), KW'(1));
    @(negedge clk);
    reset = 1'b1;
    saw = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw = 1;
    end
    chk("abort_no_done", KW'(saw), KW'(0));
    read_one(4'd0, 1'b0, '0, "rd0_after_abort");

    load_key(KeyB);
    @(negedge clk);
    bus.key_valid = 1'b0;
    wait_done(1, "done_latency_keyb");
    read_one(4'd10, 1'b1, model_rk(KeyB, 10), "rd10_keyb");
    read_one(4'd5, 1'b1, model_rk(KeyB, 5), "rd5_keyb");

    // Same-edge accept and read returns the old key; then unreadable until done
    load_key(FipsKey);
    rd_issue(4'd10, 1'b1, model_rk(KeyB, 10), "rd10_same_edge");
    @(negedge clk);
    bus.key_valid = 1'b0;
    rd_issue(4'd10, 1'b0, '0, "rd10_restarted");
    @(negedge clk);
    bus.rk_rd = 1'b0;
    wait_done(2, "done_latency_restart");
    read_one(4'd10, 1'b1, FipsRk10, "rd10_new");

`ifdef KEY_SCHED_DEC_EN
    @(negedge clk);
    bus.rk_dec = 1'b1;
    read_one(4'd0, 1'b1, FipsRk10, "dec_rd0");
    read_one(4'd10, 1'b1, FipsKey, "dec_rd10");
    bus.rk_dec = 1'b0;
`endif

    @(negedge clk);
    chk("sb_empty", KW'(sb.size()), KW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
